ps2_mouse_tracker: RTL and testbench
====================================

Name: ps2_mouse_tracker

Overview:
- Consumes the 3-byte PS/2 mouse packets from the PS/2 receiver: packet-valid pulse plus 24-bit packet.
- Byte 0 (status) is in [7:0], byte 1 (X delta) in [15:8], byte 2 (Y delta) in [23:16].
- Accumulates movement into a saturated absolute screen cursor (X, Y) and tracks button state.
- Flags malformed or dropped packets with counters; feeds the display/bus-peripheral side of the microprocessor system.

Parameters:
POS_W, 8, width of mouse_x/mouse_y
X_MAX, 159, largest legal X coordinate (X range 0..X_MAX)
Y_MAX, 119, largest legal Y coordinate (Y range 0..Y_MAX)
X_INIT, 80, X after reset/clear
Y_INIT, 60, Y after reset/clear

Ports:
clk_sys  in  1  system clock (50 MHz)
rst  in  1  asynchronous active-high reset
rd_vld  in  1  one-cycle packet-valid pulse from receiver
rd_data  in  24  packet {Y delta, X delta, status}
rd_en  out  1  ready to accept packet (1 only in S_IDLE)
pos_clr  in  1  synchronous re-centre request
mouse_x  out  POS_W  cursor X, 0..X_MAX
mouse_y  out  POS_W  cursor Y, 0..Y_MAX, 0 = top of screen
mouse_btn  out  3  {middle, right, left}
pos_upd  out  1  one-cycle pulse: new position/buttons committed
sync_err_cnt  out  8  saturating count of packets with status bit3 = 0
drop_cnt  out  8  saturating count of rd_vld pulses seen while rd_en = 0

Behaviour:
- Reset (async, active-high) values: mouse_x=X_INIT, mouse_y=Y_INIT, mouse_btn=0, pos_upd=0, sync_err_cnt=0, drop_cnt=0, FSM=S_IDLE, so rd_en=1.
- rd_en is decoded combinationally from state: 1 in S_IDLE, else 0.
- Status byte fields:
  - bits[2:0]: L, R, M buttons.
  - bit3: always 1 in a well-formed packet.
  - bit4 / bit5: X / Y sign.
  - bit6 / bit7: X / Y overflow.
- FSM states:
  - S_IDLE: on rd_vld, latch rd_data.
    - If bit3=1, go to S_CALC.
    - If bit3=0, increment sync_err_cnt (saturating at 255) and stay in S_IDLE. Position and buttons are untouched and there is no pos_upd.
  - S_CALC: form signed deltas.
    - dx = {bit4, byte1} (9-bit two's complement); dy = {bit5, byte2}.
    - If bit6=1, dx=0. If bit7=1, dy=0. Buttons are still taken from an overflowed packet.
    - Register sx = mouse_x + dx and sy = mouse_y − dy. PS/2 +Y is up; screen Y grows downward.
    - Arithmetic is signed, width POS_W+2, so no wrap-around is possible.
  - S_CLAMP: saturate and commit.
    - sx<0 → 0; sx>X_MAX → X_MAX; else sx. Same rule for sy against Y_MAX.
    - Write mouse_x, mouse_y, and mouse_btn = {M,R,L}. Go to S_DONE.
  - S_DONE: pos_upd=1 for exactly this cycle. Go to S_IDLE.
- Latency: rd_vld accepted at cycle N → outputs updated at the edge ending cycle N+2 → pos_upd high in cycle N+3. Throughput is one packet per 4 cycles, which is far faster than the PS/2 packet rate.
- rd_vld while rd_en=0 (S_CALC/S_CLAMP/S_DONE): packet discarded, drop_cnt increments (saturating), FSM unaffected.
- pos_clr:
  - When asserted in any state, mouse_x/mouse_y become X_INIT/Y_INIT on the next edge. Buttons and counters are unaffected.
  - If pos_clr coincides with the S_CLAMP commit, the clear wins for X/Y; buttons still update and pos_upd still pulses.
  - pos_clr does not alter the FSM.
- Counters hold at 255; they clear only on reset.
- Reset asserted mid-packet returns everything to reset values immediately; the partial packet is lost and no pos_upd is generated.

Test Plan:
- Reset, then packet 0x05_0A_09 (status=0x09, dx=+10, dy=+5, L pressed) → pos_upd in cycle N+3, mouse_x=90, mouse_y=55, mouse_btn=3'b001.
- From (90,55), packet status=0x38, X=0x9C, Y=0xF0 (dx=−100, dy=−16) → mouse_x=0 (saturated low), mouse_y=71, mouse_btn=0.
- From (0,71), status=0x48 (X overflow), X=0xFF, Y=0x80 (dy=+128) → mouse_x=0 (dx forced to 0), mouse_y=0 (saturated), pos_upd pulses.
- Packet with status=0x01 (bit3=0) → sync_err_cnt=1, no pos_upd, position and buttons unchanged, rd_en stays 1.
- Second rd_vld one cycle after an accepted packet → drop_cnt=1, only one pos_upd, result reflects the first packet only. Repeating this 300 times → drop_cnt=255.
- pos_clr pulsed in the same cycle as the S_CLAMP commit of packet dx=+20 → mouse_x=80, mouse_y=60, buttons updated, pos_upd=1. Reset asserted during S_CALC → all outputs at reset values, no pos_upd.

Source files
------------

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet tracker: turns 3-byte movement packets into a saturated
// absolute cursor position plus button state, with sync-error and drop counters.
module ps2_mouse_tracker #(
  parameter int POS_W  = 8,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119,
  parameter int X_INIT = 80,
  parameter int Y_INIT = 60
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             rd_vld,
  input  logic [23:0]      rd_data,
  output logic             rd_en,
  input  logic             pos_clr,
  output logic [POS_W-1:0] mouse_x,
  output logic [POS_W-1:0] mouse_y,
  output logic [2:0]       mouse_btn,
  output logic             pos_upd,
  output logic [7:0]       sync_err_cnt,
  output logic [7:0]       drop_cnt
);

  localparam int SW = POS_W + 2;
  localparam logic signed [SW-1:0] X_MAX_S  = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MAX_S  = SW'(Y_MAX);
  localparam logic [POS_W-1:0]     X_INIT_P = POS_W'(X_INIT);
  localparam logic [POS_W-1:0]     Y_INIT_P = POS_W'(Y_INIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_CLAMP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [2:0]             pkt_btn;
  logic [3:0]             pkt_flags;   // {Y ovf, X ovf, Y sign, X sign}
  logic [7:0]             pkt_dx;
  logic [7:0]             pkt_dy;
  logic signed [SW-1:0]   sx;
  logic signed [SW-1:0]   sy;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // 9-bit two's-complement delta widened to SW bits; overflow forces zero.
  function automatic logic signed [SW-1:0] delta(input logic sgn, input logic ovf,
                                                 input logic [7:0] mag);
    if (ovf) return '0;
    else     return {{(SW-9){sgn}}, sgn, mag};
  endfunction

  function automatic logic [POS_W-1:0] clamp(input logic signed [SW-1:0] v,
                                             input logic signed [SW-1:0] hi);
    if (v[SW-1])     return '0;
    else if (v > hi) return hi[POS_W-1:0];
    else             return v[POS_W-1:0];
  endfunction

  assign rd_en = (state == S_IDLE);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pkt_btn      <= 3'd0;
      pkt_flags    <= 4'd0;
      pkt_dx       <= 8'd0;
      pkt_dy       <= 8'd0;
      sx           <= '0;
      sy           <= '0;
      mouse_x      <= X_INIT_P;
      mouse_y      <= Y_INIT_P;
      mouse_btn    <= 3'd0;
      pos_upd      <= 1'b0;
      sync_err_cnt <= 8'd0;
      drop_cnt     <= 8'd0;
    end else begin
      pos_upd <= 1'b0;
      if (rd_vld && (state != S_IDLE)) drop_cnt <= sat_inc(drop_cnt);

      case (state)
        S_IDLE: begin
          if (rd_vld) begin
            pkt_btn   <= rd_data[2:0];
            pkt_flags <= rd_data[7:4];
            pkt_dx    <= rd_data[15:8];
            pkt_dy    <= rd_data[23:16];
            if (rd_data[3]) state <= S_CALC;
            else            sync_err_cnt <= sat_inc(sync_err_cnt);
          end
        end
        S_CALC: begin
          // Screen Y grows downward, so PS/2 +Y moves the cursor up.
          sx    <= $signed({2'b00, mouse_x}) + delta(pkt_flags[0], pkt_flags[2], pkt_dx);
          sy    <= $signed({2'b00, mouse_y}) - delta(pkt_flags[1], pkt_flags[3], pkt_dy);
          state <= S_CLAMP;
        end
        S_CLAMP: begin
          mouse_x   <= clamp(sx, X_MAX_S);
          mouse_y   <= clamp(sy, Y_MAX_S);
          mouse_btn <= pkt_btn;
          pos_upd   <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Re-centre overrides any same-cycle commit of X/Y.
      if (pos_clr) begin
        mouse_x <= X_INIT_P;
        mouse_y <= Y_INIT_P;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: directed and random packets
// checked against an integer cursor model.
module tb_ps2_mouse_tracker;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        rd_vld;
  logic [23:0] rd_data;
  logic        rd_en;
  logic        pos_clr;
  logic [7:0]  mouse_x;
  logic [7:0]  mouse_y;
  logic [2:0]  mouse_btn;
  logic        pos_upd;
  logic [7:0]  sync_err_cnt;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int mx, my, mb, sync_m, drop_m;

  ps2_mouse_tracker dut (
    .clk_sys(clk_sys), .rst(rst), .rd_vld(rd_vld), .rd_data(rd_data), .rd_en(rd_en),
    .pos_clr(pos_clr), .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn),
    .pos_upd(pos_upd), .sync_err_cnt(sync_err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic int ref_dx(input logic [23:0] d);
    if (d[6]) return 0;
    return d[4] ? int'(d[15:8]) - 256 : int'(d[15:8]);
  endfunction

  function automatic int ref_dy(input logic [23:0] d);
    if (d[7]) return 0;
    return d[5] ? int'(d[23:16]) - 256 : int'(d[23:16]);
  endfunction

  function automatic int clip(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Pulses rd_vld for one cycle; returns one cycle after acceptance.
  task automatic drive_pkt(input logic [23:0] d);
    rd_data = d;
    rd_vld  = 1'b1;
    step();
    rd_vld  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_vld = 1'b0; pos_clr = 1'b0; rd_data = 24'd0;
    step(); step();
    rst = 1'b0;
    step();
    mx = 80; my = 60; mb = 0; sync_m = 0; drop_m = 0;
    n_checks++; if (mouse_x !== mx) begin n_fail++; $display("FAIL reset_x: got %0d expected %0d", mouse_x, mx); end
    n_checks++; if (mouse_y !== my) begin n_fail++; $display("FAIL reset_y: got %0d expected %0d", mouse_y, my); end
    n_checks++; if (mouse_btn !== 3'd0) begin n_fail++; $display("FAIL reset_btn: got %0d expected 0", mouse_btn); end
    n_checks++; if (pos_upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %0b expected 0", pos_upd); end
    n_checks++; if (sync_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_sync: got %0d expected 0", sync_err_cnt); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL reset_rd_en: got %0b expected 1", rd_en); end
  endtask

  task automatic test_packets();
    logic [23:0] vec[$];
    logic [23:0] d;
    int nx, ny, nb;
    vec = {24'h050A09, 24'hF09C38, 24'h80FF48};
    for (int i = 0; i < 60; i++) begin
      d = 24'($urandom);
      if ($urandom_range(0, 4) != 0) d[3] = 1'b1;
      vec.push_back(d);
    end
    foreach (vec[i]) begin
      d = vec[i];
      drive_pkt(d);
      if (d[3]) begin
        nx = clip(mx + ref_dx(d), 159);
        ny = clip(my - ref_dy(d), 119);
        nb = int'(d[2:0]);
        n_checks++; if (rd_en !== 1'b0 || pos_upd !== 1'b0) begin n_fail++; $display("FAIL pkt%0d_n1: got rd_en=%0b upd=%0b expected 0/0", i, rd_en, pos_upd); end
        step();
        n_checks++; if (pos_upd !== 1'b0 || mouse_x !== mx) begin n_fail++; $display("FAIL pkt%0d_n2: got upd=%0b x=%0d expected 0/%0d", i, pos_upd, mouse_x, mx); end
        step();
        n_checks++; if (pos_upd !== 1'b1) begin n_fail++; $display("FAIL pkt%0d_upd: got %0b expected 1", i, pos_upd); end
        n_checks++; if (mouse_x !== nx) begin n_fail++; $display("FAIL pkt%0d_x: got %0d expected %0d", i, mouse_x, nx); end
        n_checks++; if (mouse_y !== ny) begin n_fail++; $display("FAIL pkt%0d_y: got %0d expected %0d", i, mouse_y, ny); end
        n_checks++; if (mouse_btn !== nb) begin n_fail++; $display("FAIL pkt%0d_btn: got %0d expected %0d", i, mouse_btn, nb); end
        mx = nx; my = ny; mb = nb;
        step();
        n_checks++; if (pos_upd !== 1'b0 || rd_en !== 1'b1) begin n_fail++; $display("FAIL pkt%0d_n4: got upd=%0b rd_en=%0b expected 0/1", i, pos_upd, rd_en); end
      end else begin
        sync_m = sat8(sync_m + 1);
        n_checks++; if (sync_err_cnt !== sync_m) begin n_fail++; $display("FAIL pkt%0d_sync: got %0d expected %0d", i, sync_err_cnt, sync_m); end
        n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL pkt%0d_sync_rd_en: got %0b expected 1", i, rd_en); end
        for (int k = 0; k < 3; k++) begin
          n_checks++; if (pos_upd !== 1'b0 || mouse_x !== mx || mouse_y !== my || mouse_btn !== mb) begin
            n_fail++; $display("FAIL pkt%0d_sync_hold: got upd=%0b x=%0d y=%0d b=%0d expected 0/%0d/%0d/%0d", i, pos_upd, mouse_x, mouse_y, mouse_btn, mx, my, mb);
          end
          step();
        end
      end
    end
  endtask

  task automatic test_sync_err();
    int s0;
    s0 = sync_m;
    drive_pkt(24'h7F7F01);
    sync_m = sat8(s0 + 1);
    n_checks++; if (sync_err_cnt !== sync_m) begin n_fail++; $display("FAIL sync_cnt: got %0d expected %0d", sync_err_cnt, sync_m); end
    n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL sync_rd_en: got %0b expected 1", rd_en); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (pos_upd !== 1'b0 || mouse_x !== mx || mouse_y !== my || mouse_btn !== mb) begin
        n_fail++; $display("FAIL sync_hold: got upd=%0b x=%0d y=%0d b=%0d expected 0/%0d/%0d/%0d", pos_upd, mouse_x, mouse_y, mouse_btn, mx, my, mb);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a, b;
    int pulses, nx, ny, nb;
    for (int i = 0; i < 300; i++) begin
      a = 24'($urandom) | 24'h000008;
      b = 24'($urandom);
      nx = clip(mx + ref_dx(a), 159);
      ny = clip(my - ref_dy(a), 119);
      nb = int'(a[2:0]);
      drive_pkt(a);
      pulses = int'(pos_upd);
      rd_data = b; rd_vld = 1'b1;
      step();
      rd_vld = 1'b0;
      pulses += int'(pos_upd);
      step(); pulses += int'(pos_upd);
      step(); pulses += int'(pos_upd);
      drop_m = sat8(drop_m + 1);
      mx = nx; my = ny; mb = nb;
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL b2b%0d_pulses: got %0d expected 1", i, pulses); end
      n_checks++; if (mouse_x !== mx || mouse_y !== my) begin n_fail++; $display("FAIL b2b%0d_pos: got %0d,%0d expected %0d,%0d", i, mouse_x, mouse_y, mx, my); end
      n_checks++; if (mouse_btn !== mb) begin n_fail++; $display("FAIL b2b%0d_btn: got %0d expected %0d", i, mouse_btn, mb); end
      n_checks++; if (drop_cnt !== drop_m) begin n_fail++; $display("FAIL b2b%0d_drop: got %0d expected %0d", i, drop_cnt, drop_m); end
      n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_rd_en: got %0b expected 1", i, rd_en); end
    end
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d expected 255", drop_cnt); end
  endtask

  task automatic test_clr();
    int nx;
    nx = clip(mx + 30, 159);
    drive_pkt(24'h001E08);
    step(); step(); step();
    mx = nx; mb = 0;
    n_checks++; if (mouse_x !== mx) begin n_fail++; $display("FAIL clr_pre_x: got %0d expected %0d", mouse_x, mx); end
    pos_clr = 1'b1;
    step();
    pos_clr = 1'b0;
    mx = 80; my = 60;
    n_checks++; if (mouse_x !== mx || mouse_y !== my) begin n_fail++; $display("FAIL clr_idle_pos: got %0d,%0d expected %0d,%0d", mouse_x, mouse_y, mx, my); end
    n_checks++; if (mouse_btn !== mb || sync_err_cnt !== sync_m || drop_cnt !== drop_m) begin
      n_fail++; $display("FAIL clr_idle_keep: got b=%0d s=%0d d=%0d expected %0d/%0d/%0d", mouse_btn, sync_err_cnt, drop_cnt, mb, sync_m, drop_m);
    end
    // Clear coinciding with the commit edge of a dx=+20 packet.
    drive_pkt(24'h00140E);
    step();
    pos_clr = 1'b1;
    step();
    pos_clr = 1'b0;
    mb = 6;
    n_checks++; if (mouse_x !== 80 || mouse_y !== 60) begin n_fail++; $display("FAIL clr_commit_pos: got %0d,%0d expected 80,60", mouse_x, mouse_y); end
    n_checks++; if (mouse_btn !== mb) begin n_fail++; $display("FAIL clr_commit_btn: got %0d expected %0d", mouse_btn, mb); end
    n_checks++; if (pos_upd !== 1'b1) begin n_fail++; $display("FAIL clr_commit_upd: got %0b expected 1", pos_upd); end
    step();
    n_checks++; if (pos_upd !== 1'b0 || rd_en !== 1'b1) begin n_fail++; $display("FAIL clr_commit_done: got upd=%0b rd_en=%0b expected 0/1", pos_upd, rd_en); end
  endtask

  task automatic test_reset_mid();
    drive_pkt(24'h00050F);
    #1 rst = 1'b1;
    #1;
    mx = 80; my = 60; mb = 0; sync_m = 0; drop_m = 0;
    n_checks++; if (mouse_x !== mx || mouse_y !== my || mouse_btn !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_pos: got %0d,%0d,%0d expected 80,60,0", mouse_x, mouse_y, mouse_btn);
    end
    n_checks++; if (sync_err_cnt !== 8'd0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d,%0d expected 0,0", sync_err_cnt, drop_cnt); end
    n_checks++; if (rd_en !== 1'b1 || pos_upd !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctl: got rd_en=%0b upd=%0b expected 1/0", rd_en, pos_upd); end
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (pos_upd !== 1'b0 || mouse_x !== mx || mouse_btn !== 3'd0 || rd_en !== 1'b1) begin
        n_fail++; $display("FAIL rstmid_after%0d: got upd=%0b x=%0d b=%0d rd_en=%0b expected 0/80/0/1", k, pos_upd, mouse_x, mouse_btn, rd_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_packets();
    test_sync_err();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
